// File: rtl/inter_rr.sv
// N-master to M-slave single-transfer interconnect with round-robin arbitration.
// Optional macro INTER_RR_DECERR_EN adds decode_err and drops out-of-range slave ids.
module inter_rr #(
    parameter  int NUM_MASTER = 3,
    parameter  int NUM_SLAVE  = 2,
    parameter  int ADDR_W     = 3,
    parameter  int DATA_W     = 3,
    localparam int SID_W      = (NUM_SLAVE > 2) ? $clog2(NUM_SLAVE) : 1,
    localparam int REQ_W      = SID_W + ADDR_W + DATA_W,
    localparam int GID_W      = $clog2(NUM_MASTER)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTER-1:0]       in_valid,
    output logic [NUM_MASTER-1:0]       in_ready,
    input  logic [NUM_MASTER*REQ_W-1:0] data_in,
    input  logic [NUM_SLAVE-1:0]        ready_slave,
    output logic [NUM_SLAVE-1:0]        valid_slave,
    output logic [ADDR_W-1:0]           addr_out,
    output logic [DATA_W-1:0]           value_out,
    output logic [NUM_SLAVE-1:0]        handshake_slave,
`ifdef INTER_RR_DECERR_EN
    output logic                        decode_err,
`endif
    output logic [GID_W-1:0]            grant_id
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t                             r_state, w_state_nxt;
    logic [NUM_MASTER-1:0][REQ_W-1:0]   r_req;
    logic [NUM_MASTER-1:0]              r_pend, w_clr;
    logic [GID_W-1:0]                   r_ptr, w_ptr_nxt, r_gid, w_gid_nxt, w_g;
    logic                               w_any, w_bad, w_xfer;
    logic [REQ_W-1:0]                   w_word;
    logic [SID_W-1:0]                   w_sid, w_sid_eff;
    logic [NUM_SLAVE-1:0]               r_valid, w_valid_nxt, r_hs, w_hs_nxt, w_onehot;
    logic [ADDR_W-1:0]                  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]                  r_value, w_value_nxt;
`ifdef INTER_RR_DECERR_EN
    logic                               r_derr, w_derr_nxt;
`endif

    function automatic logic [GID_W-1:0] inc_mod(input logic [GID_W-1:0] g);
        return (g == GID_W'(NUM_MASTER - 1)) ? '0 : g + 1'b1;
    endfunction

    assign in_ready = ~r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req  <= '0;
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTER; i++) begin
                if (in_valid[i] && !r_pend[i]) begin
                    r_req[i]  <= data_in[i*REQ_W +: REQ_W];
                    r_pend[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // First pending master at or after r_ptr, wrapping.
    always_comb begin
        int j;
        j     = 0;
        w_any = 1'b0;
        w_g   = '0;
        for (int k = 0; k < NUM_MASTER; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_MASTER) j = j - NUM_MASTER;
            if (!w_any && r_pend[j]) begin
                w_any = 1'b1;
                w_g   = GID_W'(j);
            end
        end
    end

    assign w_word    = r_req[w_g];
    assign w_sid     = w_word[REQ_W-1 -: SID_W];
    assign w_bad     = (int'(w_sid) >= NUM_SLAVE);
    assign w_sid_eff = w_bad ? SID_W'(NUM_SLAVE - 1) : w_sid;
    assign w_onehot  = NUM_SLAVE'(1) << w_sid_eff;
    assign w_xfer    = |(r_valid & ready_slave);

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_value_nxt = r_value;
        w_hs_nxt    = '0;
        w_gid_nxt   = r_gid;
        w_ptr_nxt   = r_ptr;
        w_clr       = '0;
`ifdef INTER_RR_DECERR_EN
        w_derr_nxt  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_any) begin
                    w_gid_nxt = w_g;
`ifdef INTER_RR_DECERR_EN
                    if (w_bad) begin
                        w_clr       = NUM_MASTER'(1) << w_g;
                        w_ptr_nxt   = inc_mod(w_g);
                        w_derr_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else
`endif
                    begin
                        w_valid_nxt = w_onehot;
                        w_addr_nxt  = w_word[DATA_W +: ADDR_W];
                        w_value_nxt = w_word[DATA_W-1:0];
                        w_state_nxt = S_SEND;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_valid_nxt = '0;
                    w_addr_nxt  = '0;
                    w_value_nxt = '0;
                    w_hs_nxt    = r_valid;
                    w_clr       = NUM_MASTER'(1) << r_gid;
                    w_ptr_nxt   = inc_mod(r_gid);
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_addr  <= '0;
            r_value <= '0;
            r_hs    <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
`ifdef INTER_RR_DECERR_EN
            r_derr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_value <= w_value_nxt;
            r_hs    <= w_hs_nxt;
            r_gid   <= w_gid_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef INTER_RR_DECERR_EN
            r_derr  <= w_derr_nxt;
`endif
        end
    end

    assign valid_slave     = r_valid;
    assign addr_out        = r_addr;
    assign value_out       = r_value;
    assign handshake_slave = r_hs;
    assign grant_id        = r_gid;
`ifdef INTER_RR_DECERR_EN
    assign decode_err      = r_derr;
`endif
endmodule

// File: tb/tb_inter_rr.sv
// Directed bench for inter_rr: vector table plus reset/backpressure/out-of-range-slave sequences.
module tb_inter_rr;
    localparam int NM = 3, NS = 2, AW = 3, DW = 3, RW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NM-1:0]   in_valid, in_ready;
    logic [NM*RW-1:0] data_in;
    logic [NS-1:0]   ready_slave, valid_slave, handshake_slave;
    logic [AW-1:0]   addr_out;
    logic [DW-1:0]   value_out;
    logic [1:0]      grant_id;

    // Second instance with three slaves: out-of-range ids route to the last slave.
    logic [2:0]      iv3, ir3, rs3, vs3, hs3;
    logic [23:0]     d3;
    logic [2:0]      a3, v3;
    logic [1:0]      g3;

    always #5 clk = ~clk;

    inter_rr dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .ready_slave(ready_slave), .valid_slave(valid_slave),
        .addr_out(addr_out), .value_out(value_out), .handshake_slave(handshake_slave),
        .grant_id(grant_id)
    );

    inter_rr #(.NUM_SLAVE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
        .data_in(d3), .ready_slave(rs3), .valid_slave(vs3),
        .addr_out(a3), .value_out(v3), .handshake_slave(hs3),
        .grant_id(g3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  iv;
        logic [20:0] din;
        logic [1:0]  rs;
        logic [2:0]  ir;
        logic [1:0]  vs;
        logic [2:0]  a;
        logic [2:0]  v;
        logic [1:0]  hs;
        logic [1:0]  gid;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [2:0] iv, input logic [20:0] din,
                                input logic [1:0] rs, input logic [2:0] ir, input logic [1:0] vs,
                                input logic [2:0] a, input logic [2:0] v, input logic [1:0] hs,
                                input logic [1:0] gid);
        vec_t t;
        t.rst = rst; t.iv = iv; t.din = din; t.rs = rs; t.ir = ir;
        t.vs = vs; t.a = a; t.v = v; t.hs = hs; t.gid = gid;
        return t;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0; data_in = '0; ready_slave = '0;
        iv3 = '0; d3 = '0; rs3 = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_main(input string tag, input logic [2:0] ir, input logic [1:0] vs,
                            input logic [2:0] a, input logic [2:0] v, input logic [1:0] hs,
                            input logic [1:0] gid);
        chk({tag, " in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, " valid_slave"}, 32'(valid_slave), 32'(vs));
        chk({tag, " addr_out"}, 32'(addr_out), 32'(a));
        chk({tag, " value_out"}, 32'(value_out), 32'(v));
        chk({tag, " handshake"}, 32'(handshake_slave), 32'(hs));
        chk({tag, " grant_id"}, 32'(grant_id), 32'(gid));
    endtask

    vec_t tbl [17];

    initial begin
        logic [6:0]  ws, w0, w1, w2;
        logic [20:0] drr;
        ws  = 7'b0_011_110;
        w0  = 7'b0_001_001;
        w1  = 7'b1_010_010;
        w2  = 7'b0_011_100;
        drr = {w2, w1, w0};

        // single request: master0 -> slave0, addr 3, value 6
        tbl[0]  = mk(1, 3'b001, {14'b0, ws}, 2'b01, 3'b110, 2'b00, 0, 0, 2'b00, 0);
        tbl[1]  = mk(0, 3'b000, {14'b0, ws}, 2'b01, 3'b110, 2'b01, 3, 6, 2'b00, 0);
        tbl[2]  = mk(0, 3'b000, {14'b0, ws}, 2'b01, 3'b111, 2'b00, 0, 0, 2'b01, 0);
        tbl[3]  = mk(0, 3'b000, {14'b0, ws}, 2'b01, 3'b111, 2'b00, 0, 0, 2'b00, 0);
        // all masters posting continuously, slaves always ready
        tbl[4]  = mk(1, 3'b111, drr, 2'b11, 3'b000, 2'b00, 0, 0, 2'b00, 0);
        tbl[5]  = mk(0, 3'b111, drr, 2'b11, 3'b000, 2'b01, 1, 1, 2'b00, 0);
        tbl[6]  = mk(0, 3'b111, drr, 2'b11, 3'b001, 2'b00, 0, 0, 2'b01, 0);
        tbl[7]  = mk(0, 3'b111, drr, 2'b11, 3'b000, 2'b10, 2, 2, 2'b00, 1);
        tbl[8]  = mk(0, 3'b111, drr, 2'b11, 3'b010, 2'b00, 0, 0, 2'b10, 1);
        tbl[9]  = mk(0, 3'b111, drr, 2'b11, 3'b000, 2'b01, 3, 4, 2'b00, 2);
        tbl[10] = mk(0, 3'b111, drr, 2'b11, 3'b100, 2'b00, 0, 0, 2'b01, 2);
        tbl[11] = mk(0, 3'b111, drr, 2'b11, 3'b000, 2'b01, 1, 1, 2'b00, 0);
        tbl[12] = mk(0, 3'b111, drr, 2'b11, 3'b001, 2'b00, 0, 0, 2'b01, 0);
        tbl[13] = mk(0, 3'b111, drr, 2'b11, 3'b000, 2'b10, 2, 2, 2'b00, 1);
        tbl[14] = mk(0, 3'b111, drr, 2'b11, 3'b010, 2'b00, 0, 0, 2'b10, 1);
        tbl[15] = mk(0, 3'b111, drr, 2'b11, 3'b000, 2'b01, 3, 4, 2'b00, 2);
        tbl[16] = mk(0, 3'b111, drr, 2'b11, 3'b100, 2'b00, 0, 0, 2'b01, 2);

        do_reset();
        chk_main("reset", 3'b111, 2'b00, 0, 0, 2'b00, 0);
        chk("reset dut3 in_ready", 32'(ir3), 32'(3'b111));
        chk("reset dut3 valid", 32'(vs3), 0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            in_valid    = tbl[i].iv;
            data_in     = tbl[i].din;
            ready_slave = tbl[i].rs;
            @(posedge clk); #1;
            chk_main($sformatf("row%0d", i), tbl[i].ir, tbl[i].vs, tbl[i].a, tbl[i].v,
                     tbl[i].hs, tbl[i].gid);
        end

        // backpressure: master2 -> slave1 held off for 5 cycles, slave0 ready toggling
        do_reset();
        in_valid = 3'b100;
        data_in  = {7'b1_101_011, 14'b0};
        @(posedge clk); #1;
        in_valid = '0;
        @(posedge clk); #1;
        chk_main("bp grant", 3'b011, 2'b10, 5, 3, 2'b00, 2);
        for (int c = 0; c < 5; c++) begin
            ready_slave = (c % 2 == 0) ? 2'b01 : 2'b00;
            @(posedge clk); #1;
            chk_main($sformatf("bp hold%0d", c), 3'b011, 2'b10, 5, 3, 2'b00, 2);
        end
        ready_slave = 2'b10;
        @(posedge clk); #1;
        chk_main("bp xfer", 3'b111, 2'b00, 0, 0, 2'b10, 2);
        ready_slave = 2'b00;
        @(posedge clk); #1;
        chk_main("bp done", 3'b111, 2'b00, 0, 0, 2'b00, 2);

        // reset asserted while master1's transfer is stalled in S_SEND
        do_reset();
        in_valid = 3'b010;
        data_in  = {7'b0, 7'b1_010_101, 7'b0};
        @(posedge clk); #1;
        in_valid = '0;
        @(posedge clk); #1;
        chk_main("mid send", 3'b101, 2'b10, 2, 5, 2'b00, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_main("async reset", 3'b111, 2'b00, 0, 0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_slave = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post reset hs%0d", c), 32'(handshake_slave), 0);
            chk($sformatf("post reset vs%0d", c), 32'(valid_slave), 0);
        end

        // three-slave instance: slave_id 3 is out of range and goes to slave 2
        do_reset();
        iv3 = 3'b001;
        d3  = {16'b0, 8'b11_110_111};
        @(posedge clk); #1;
        iv3 = '0;
        chk("oor capture in_ready", 32'(ir3), 32'(3'b110));
        @(posedge clk); #1;
        chk("oor valid", 32'(vs3), 32'(3'b100));
        chk("oor addr", 32'(a3), 6);
        chk("oor value", 32'(v3), 7);
        rs3 = 3'b011;
        @(posedge clk); #1;
        chk("oor ignore other ready", 32'(vs3), 32'(3'b100));
        chk("oor no hs", 32'(hs3), 0);
        rs3 = 3'b100;
        @(posedge clk); #1;
        chk("oor hs", 32'(hs3), 32'(3'b100));
        chk("oor valid drop", 32'(vs3), 0);
        chk("oor in_ready", 32'(ir3), 32'(3'b111));
        rs3 = '0;
        @(posedge clk); #1;
        chk("oor hs clear", 32'(hs3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
